// File: rtl/popcnt_pkg.sv
// Shared widths and configuration helpers for the pipelined population counter.
// All derived widths come from clog2 so odd WIDTH/LANE combinations size exactly.
package popcnt_pkg;

   localparam int WIDTH_DEF = 64;
   localparam int LANE_DEF  = 8;
   localparam int ACC_W_DEF = 16;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

   // CW: width of a whole-word count; LW: width of one lane count
   function automatic int cw_of(input int width);
      return clog2(width + 1);
   endfunction

   function automatic int lw_of(input int lane);
      return clog2(lane + 1);
   endfunction

   function automatic bit cfg_ok(input int width, input int lane, input int acc_w);
      return (width > 0) && (lane > 0) && (width % lane == 0) && (acc_w >= cw_of(width));
   endfunction

endpackage

// File: rtl/popcnt_if.sv
// Word-in / result-out handshake bundle for popcnt_pipe.
// master drives words and out_ready; slave is the counting engine.
interface popcnt_if import popcnt_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF,
   parameter int ACC_W = ACC_W_DEF
);
   localparam int CW = cw_of(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_word;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [CW-1:0]    out_count;
   logic [ACC_W-1:0] out_total;
   logic             out_last;
   logic             out_sat;

   modport master (
      output in_valid, in_word, in_last, out_ready,
      input  in_ready, out_valid, out_count, out_total, out_last, out_sat
   );

   modport slave (
      input  in_valid, in_word, in_last, out_ready,
      output in_ready, out_valid, out_count, out_total, out_last, out_sat
   );
endinterface

// File: rtl/popcnt_lane.sv
// Combinational ones-count of one LANE-bit slice; no state, no handshake.
module popcnt_lane import popcnt_pkg::*; #(
   parameter int LANE = LANE_DEF,
   parameter int LW   = lw_of(LANE)
) (
   input  logic [LANE-1:0] bits,
   output logic [LW-1:0]   cnt
);
   always_comb begin
      cnt = '0;
      for (int i = 0; i < LANE; i++) cnt = cnt + LW'(bits[i]);
   end
endmodule

// File: rtl/popcnt_pipe.sv
// Two-stage popcount with saturating per-frame total; result 2 cycles after accept.
// Single global enable: out_valid & !out_ready freezes every stage and drops in_ready.
module popcnt_pipe import popcnt_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF,
   parameter int LANE  = LANE_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic    clk,
   input  logic    rst_n,
   popcnt_if.slave bus
);
   localparam int NLANE = WIDTH / LANE;
   localparam int LW    = lw_of(LANE);
   localparam int CW    = cw_of(WIDTH);
   localparam int AW1   = ACC_W + 1;

   if (!cfg_ok(WIDTH, LANE, ACC_W)) begin : g_cfg_err
      $error("popcnt_pipe: WIDTH must be a multiple of LANE and ACC_W >= clog2(WIDTH+1)");
   end

   logic                     en;
   logic [NLANE-1:0][LW-1:0] lane_cnt;
   logic [NLANE-1:0][LW-1:0] s1_cnt;
   logic                     s1_vld;
   logic                     s1_last;
   logic [CW-1:0]            tree_sum;
   logic [ACC_W-1:0]         acc;
   logic [ACC_W-1:0]         acc_next;
   logic [ACC_W:0]           acc_sum;
   logic                     sat;
   logic                     sat_next;
   logic                     out_vld_q;
   logic [CW-1:0]            out_count_q;
   logic [ACC_W-1:0]         out_total_q;
   logic                     out_last_q;
   logic                     out_sat_q;

   assign en           = !out_vld_q || bus.out_ready;
   assign bus.in_ready = en;

   for (genvar g = 0; g < NLANE; g++) begin : g_lane
      popcnt_lane #(.LANE(LANE), .LW(LW)) u_lane (
         .bits (bus.in_word[g*LANE +: LANE]),
         .cnt  (lane_cnt[g])
      );
   end

   always_comb begin
      tree_sum = '0;
      for (int i = 0; i < NLANE; i++) tree_sum = tree_sum + CW'(s1_cnt[i]);
   end

   // One extra bit catches the overflow that pins the total and sets the sticky flag
   assign acc_sum  = {1'b0, acc} + AW1'(tree_sum);
   assign acc_next = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
   assign sat_next = sat | acc_sum[ACC_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld      <= 1'b0;
         s1_last     <= 1'b0;
         s1_cnt      <= '0;
         out_vld_q   <= 1'b0;
         out_count_q <= '0;
         out_total_q <= '0;
         out_last_q  <= 1'b0;
         out_sat_q   <= 1'b0;
         acc         <= '0;
         sat         <= 1'b0;
      end else if (en) begin
         s1_vld    <= bus.in_valid;
         s1_last   <= bus.in_last;
         s1_cnt    <= lane_cnt;
         out_vld_q <= s1_vld;
         if (s1_vld) begin
            out_count_q <= tree_sum;
            out_total_q <= acc_next;
            out_last_q  <= s1_last;
            out_sat_q   <= sat_next;
            acc         <= s1_last ? '0 : acc_next;
            sat         <= s1_last ? 1'b0 : sat_next;
         end
      end
   end

   assign bus.out_valid = out_vld_q;
   assign bus.out_count = out_count_q;
   assign bus.out_total = out_total_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_popcnt_pipe.sv
// Directed bench for popcnt_pipe across five parameter sets sharing one clock and reset.
module tb_popcnt_pipe;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   popcnt_if #(.WIDTH(64),  .ACC_W(16)) b0 ();
   popcnt_if #(.WIDTH(64),  .ACC_W(8))  b1 ();
   popcnt_if #(.WIDTH(8),   .ACC_W(16)) b2 ();
   popcnt_if #(.WIDTH(128), .ACC_W(16)) b3 ();
   popcnt_if #(.WIDTH(96),  .ACC_W(16)) b4 ();

   popcnt_pipe #(.WIDTH(64),  .LANE(8),  .ACC_W(16)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   popcnt_pipe #(.WIDTH(64),  .LANE(8),  .ACC_W(8))  u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   popcnt_pipe #(.WIDTH(8),   .LANE(8),  .ACC_W(16)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
   popcnt_pipe #(.WIDTH(128), .LANE(16), .ACC_W(16)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
   popcnt_pipe #(.WIDTH(96),  .LANE(4),  .ACC_W(16)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

   function automatic int pc(input logic [127:0] v, input int n);
      int r;
      r = 0;
      for (int i = 0; i < n; i++) r += int'(v[i]);
      return r;
   endfunction

   task automatic idle_all();
      b0.in_valid = 1'b0; b0.in_last = 1'b0; b0.in_word = '0; b0.out_ready = 1'b1;
      b1.in_valid = 1'b0; b1.in_last = 1'b0; b1.in_word = '0; b1.out_ready = 1'b1;
      b2.in_valid = 1'b0; b2.in_last = 1'b0; b2.in_word = '0; b2.out_ready = 1'b1;
      b3.in_valid = 1'b0; b3.in_last = 1'b0; b3.in_word = '0; b3.out_ready = 1'b1;
      b4.in_valid = 1'b0; b4.in_last = 1'b0; b4.in_word = '0; b4.out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_all();
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (b0.out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_out_valid got %b want 0", b0.out_valid); end
      n_checks++; if (b0.out_count !== 7'd0) begin n_errors++; $display("FAIL rst_out_count got %0d want 0", b0.out_count); end
      n_checks++; if (b0.out_total !== 16'd0) begin n_errors++; $display("FAIL rst_out_total got %0d want 0", b0.out_total); end
      n_checks++; if (b0.out_last !== 1'b0) begin n_errors++; $display("FAIL rst_out_last got %b want 0", b0.out_last); end
      n_checks++; if (b0.out_sat !== 1'b0) begin n_errors++; $display("FAIL rst_out_sat got %b want 0", b0.out_sat); end
      n_checks++; if (b0.in_ready !== 1'b1) begin n_errors++; $display("FAIL rst_in_ready got %b want 1", b0.in_ready); end
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      n_checks++; if (b0.in_ready !== 1'b1) begin n_errors++; $display("FAIL idle_in_ready got %b want 1", b0.in_ready); end
      n_checks++; if (b0.out_valid !== 1'b0) begin n_errors++; $display("FAIL idle_out_valid got %b want 0", b0.out_valid); end
   endtask

   task automatic test_basic();
      logic [63:0] w  [3] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0F0F_0000_0000_0001};
      int          ec [3] = '{0, 64, 9};
      int          et [3] = '{0, 64, 73};
      logic        el [3] = '{1'b0, 1'b0, 1'b1};
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c < 3) begin
            b0.in_valid = 1'b1; b0.in_word = w[c]; b0.in_last = (c == 2);
         end else begin
            b0.in_valid = 1'b0; b0.in_word = '0; b0.in_last = 1'b0;
         end
         #1;
         if (c >= 2 && c < 5) begin
            n_checks++; if (b0.out_valid !== 1'b1) begin n_errors++; $display("FAIL basic_valid[%0d] got %b want 1", c-2, b0.out_valid); end
            n_checks++; if (b0.out_count !== 7'(ec[c-2])) begin n_errors++; $display("FAIL basic_count[%0d] got %0d want %0d", c-2, b0.out_count, ec[c-2]); end
            n_checks++; if (b0.out_total !== 16'(et[c-2])) begin n_errors++; $display("FAIL basic_total[%0d] got %0d want %0d", c-2, b0.out_total, et[c-2]); end
            n_checks++; if (b0.out_last !== el[c-2]) begin n_errors++; $display("FAIL basic_last[%0d] got %b want %b", c-2, b0.out_last, el[c-2]); end
         end else begin
            n_checks++; if (b0.out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_latency cycle %0d got valid %b want 0", c, b0.out_valid); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] w  [8] = '{64'h0000_0000_0000_00FF, 64'hFFFF_0000_0000_0000, 64'h8000_0000_0000_0001,
                              64'hAAAA_AAAA_AAAA_AAAA, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF,
                              64'h0123_4567_89AB_CDEF};
      int          ec [8] = '{8, 16, 2, 32, 0, 1, 64, 32};
      int          et [8] = '{8, 24, 26, 58, 0, 1, 65, 97};
      logic        el [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int          in_i = 0;
      int          out_i = 0;
      int          cyc = 0;
      logic        held = 1'b0;
      logic [6:0]  h_cnt = '0;
      logic [15:0] h_tot = '0;
      logic        h_last = 1'b0;
      while (out_i < 8 && cyc < 100) begin
         @(negedge clk);
         b0.out_ready = pat[cyc % 4];
         if (in_i < 8) begin
            b0.in_valid = 1'b1; b0.in_word = w[in_i]; b0.in_last = el[in_i];
         end else begin
            b0.in_valid = 1'b0; b0.in_word = '0; b0.in_last = 1'b0;
         end
         #1;
         n_checks++; if (b0.in_ready !== !(b0.out_valid && !b0.out_ready)) begin n_errors++; $display("FAIL b2b_in_ready cycle %0d got %b with out_valid %b out_ready %b", cyc, b0.in_ready, b0.out_valid, b0.out_ready); end
         if (held) begin
            n_checks++; if (b0.out_valid !== 1'b1 || b0.out_count !== h_cnt || b0.out_total !== h_tot || b0.out_last !== h_last)
               begin n_errors++; $display("FAIL b2b_hold cycle %0d got v%b c%0d t%0d l%b want v1 c%0d t%0d l%b", cyc, b0.out_valid, b0.out_count, b0.out_total, b0.out_last, h_cnt, h_tot, h_last); end
         end
         if (b0.out_valid && b0.out_ready) begin
            n_checks++; if (b0.out_count !== 7'(ec[out_i]) || b0.out_total !== 16'(et[out_i]) || b0.out_last !== el[out_i])
               begin n_errors++; $display("FAIL b2b_result[%0d] got c%0d t%0d l%b want c%0d t%0d l%b", out_i, b0.out_count, b0.out_total, b0.out_last, ec[out_i], et[out_i], el[out_i]); end
            out_i++;
         end
         held   = b0.out_valid && !b0.out_ready;
         h_cnt  = b0.out_count;
         h_tot  = b0.out_total;
         h_last = b0.out_last;
         if (b0.in_valid && b0.in_ready) in_i++;
         cyc++;
      end
      n_checks++; if (out_i != 8) begin n_errors++; $display("FAIL b2b_timeout delivered %0d want 8", out_i); end
      @(negedge clk);
      b0.in_valid = 1'b0; b0.out_ready = 1'b1;
      #1;
      n_checks++; if (b0.out_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_duplicate got valid %b want 0", b0.out_valid); end
   endtask

   task automatic test_saturation();
      int   et [6] = '{64, 128, 192, 255, 255, 64};
      logic es [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         b1.in_valid = (c < 6);
         b1.in_word  = (c < 6) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
         b1.in_last  = (c == 4) || (c == 5);
         #1;
         if (c >= 2 && c < 8) begin
            n_checks++; if (b1.out_valid !== 1'b1 || b1.out_count !== 7'd64) begin n_errors++; $display("FAIL sat_word[%0d] got v%b c%0d want v1 c64", c-2, b1.out_valid, b1.out_count); end
            n_checks++; if (b1.out_total !== 8'(et[c-2])) begin n_errors++; $display("FAIL sat_total[%0d] got %0d want %0d", c-2, b1.out_total, et[c-2]); end
            n_checks++; if (b1.out_sat !== es[c-2]) begin n_errors++; $display("FAIL sat_flag[%0d] got %b want %b", c-2, b1.out_sat, es[c-2]); end
         end
      end
      b1.in_valid = 1'b0; b1.in_last = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      logic [63:0] w [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_000F_FFFF_FFFF, 64'hFF, 64'hFF};
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         b0.in_valid = 1'b1; b0.in_word = w[c]; b0.in_last = 1'b0;
         #1;
      end
      n_checks++; if (b0.out_valid !== 1'b1 || b0.out_total !== 16'd100) begin n_errors++; $display("FAIL midrst_pre_total got v%b t%0d want v1 t100", b0.out_valid, b0.out_total); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (b0.out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_valid got %b want 0", b0.out_valid); end
      n_checks++; if (b0.out_total !== 16'd0 || b0.out_count !== 7'd0 || b0.out_sat !== 1'b0 || b0.out_last !== 1'b0)
         begin n_errors++; $display("FAIL midrst_clear got c%0d t%0d s%b l%b want all 0", b0.out_count, b0.out_total, b0.out_sat, b0.out_last); end
      idle_all();
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         b0.in_valid = (c == 0); b0.in_word = (c == 0) ? 64'h7 : 64'h0; b0.in_last = (c == 0);
         #1;
         if (c == 2) begin
            n_checks++; if (b0.out_valid !== 1'b1 || b0.out_count !== 7'd3 || b0.out_total !== 16'd3 || b0.out_last !== 1'b1)
               begin n_errors++; $display("FAIL midrst_first got v%b c%0d t%0d l%b want v1 c3 t3 l1", b0.out_valid, b0.out_count, b0.out_total, b0.out_last); end
         end
      end
      b0.in_valid = 1'b0; b0.in_last = 1'b0;
   endtask

   task automatic test_param_sweep();
      logic [127:0] vec [16];
      int           e2 [16], e3 [16], e4 [16];
      int           t2 [16], t3 [16], t4 [16];
      int           a2 = 0, a3 = 0, a4 = 0;
      vec[0] = 128'h1;
      vec[1] = 128'h80;
      vec[2] = 128'h1 << 95;
      vec[3] = 128'h1 << 127;
      vec[4] = {16{8'hAA}};
      vec[5] = {16{8'h55}};
      for (int i = 6; i < 16; i++) vec[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      for (int i = 0; i < 16; i++) begin
         e2[i] = pc(vec[i], 8);   a2 += e2[i]; t2[i] = a2;
         e3[i] = pc(vec[i], 128); a3 += e3[i]; t3[i] = a3;
         e4[i] = pc(vec[i], 96);  a4 += e4[i]; t4[i] = a4;
         if (i % 2 == 1) begin a2 = 0; a3 = 0; a4 = 0; end
      end
      for (int c = 0; c < 18; c++) begin
         @(negedge clk);
         b2.in_valid = (c < 16); b3.in_valid = (c < 16); b4.in_valid = (c < 16);
         b2.in_last = (c % 2 == 1); b3.in_last = (c % 2 == 1); b4.in_last = (c % 2 == 1);
         if (c < 16) begin
            b2.in_word = vec[c][7:0]; b3.in_word = vec[c]; b4.in_word = vec[c][95:0];
         end
         #1;
         if (c >= 2) begin
            n_checks++; if (b2.out_valid !== 1'b1 || 32'(b2.out_count) !== 32'(e2[c-2]) || 32'(b2.out_total) !== 32'(t2[c-2]))
               begin n_errors++; $display("FAIL sweep_w8[%0d] got v%b c%0d t%0d want c%0d t%0d", c-2, b2.out_valid, b2.out_count, b2.out_total, e2[c-2], t2[c-2]); end
            n_checks++; if (b3.out_valid !== 1'b1 || 32'(b3.out_count) !== 32'(e3[c-2]) || 32'(b3.out_total) !== 32'(t3[c-2]))
               begin n_errors++; $display("FAIL sweep_w128[%0d] got v%b c%0d t%0d want c%0d t%0d", c-2, b3.out_valid, b3.out_count, b3.out_total, e3[c-2], t3[c-2]); end
            n_checks++; if (b4.out_valid !== 1'b1 || 32'(b4.out_count) !== 32'(e4[c-2]) || 32'(b4.out_total) !== 32'(t4[c-2]))
               begin n_errors++; $display("FAIL sweep_w96[%0d] got v%b c%0d t%0d want c%0d t%0d", c-2, b4.out_valid, b4.out_count, b4.out_total, e4[c-2], t4[c-2]); end
            n_checks++; if (b4.out_last !== ((c - 2) % 2 == 1)) begin n_errors++; $display("FAIL sweep_last[%0d] got %b", c-2, b4.out_last); end
         end
      end
      idle_all();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_saturation();
      test_reset_mid_frame();
      test_param_sweep();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish, errors so far %0d", n_errors);
      $fatal(1, "watchdog");
   end

endmodule
